// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
//   - WIDTH / CNT_W: data and shift-count widths (fixed at 16 / 4)
//   - OP_*: operation encodings
//   - state_e: sequencer FSM states
//   - first_set_stage(): maps a (masked) count to the first stage whose bit is set,
//     used only when SHIFT_SKIP_ZERO_EN is defined
package shift_sequencer_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    St8,
    St4,
    St2,
    St1,
    StDone
  } state_e;

  // Highest set bit of c selects the next stage; no bits set means go straight to StDone.
  function automatic state_e first_set_stage(input logic [CNT_W-1:0] c);
    if (c[3]) begin
      return St8;
    end else if (c[2]) begin
      return St4;
    end else if (c[1]) begin
      return St2;
    end else if (c[0]) begin
      return St1;
    end
    return StDone;
  endfunction

endpackage

// File: rtl/shift_sequencer_shift_stage.sv
// shift_stage: combinational single-stage shifter, reused by the sequencer every cycle.
// Ports:
//   data  - stage input operand
//   op    - OP_ROL / OP_SLL / OP_SRA / OP_SRL
//   amt   - stage amount (8, 4, 2 or 1; 0 passes data through)
//   res   - shifted result
module shift_stage
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] res
);

  // Right-shift amount that completes a rotate; amt = 0 gives 16, which shifts out fully.
  logic [CNT_W:0] rot_back;
  assign rot_back = 5'd16 - {1'b0, amt};

  always_comb begin
    res = data;
    unique case (op)
      OP_ROL:  res = (data << amt) | (data >> rot_back);
      OP_SLL:  res = data << amt;
      OP_SRA:  res = $signed(data) >>> amt;
      OP_SRL:  res = data >> amt;
      default: res = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 16-bit shift/rotate controller. Applies one power-of-two
// stage (8, 4, 2, 1) per clock to an internal data register, then registers the result.
// Ports:
//   clk, rst - clock (rising edge) and synchronous active-high reset
//   start    - request, sampled only while idle
//   op       - 00 ROL, 01 SLL, 10 SRA, 11 SRL
//   cnt      - shift amount 0..15
//   in       - operand
//   busy     - operation in progress (not idle)
//   done     - one-cycle pulse, out valid
//   out      - result register, holds until the next completion
// Build option: define SHIFT_SKIP_ZERO_EN to skip stages whose count bit is zero
// (latency popcount(cnt)+1 instead of a fixed 5 cycles; results identical).
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic [CNT_W-1:0] stage_amt;
  logic             stage_take;
  logic [WIDTH-1:0] stage_res;

  shift_stage u_stage (
    .data (data_q),
    .op   (op_q),
    .amt  (stage_amt),
    .res  (stage_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    out_d      = out_q;
    stage_amt  = '0;
    stage_take = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d   = op;
          cnt_d  = cnt;
          data_d = in;
`ifdef SHIFT_SKIP_ZERO_EN
          state_d = first_set_stage(cnt);
`else
          state_d = St8;
`endif
        end
      end
      St8: begin
        stage_amt  = 4'd8;
        stage_take = cnt_q[3];
`ifdef SHIFT_SKIP_ZERO_EN
        state_d = first_set_stage({1'b0, cnt_q[2:0]});
`else
        state_d = St4;
`endif
      end
      St4: begin
        stage_amt  = 4'd4;
        stage_take = cnt_q[2];
`ifdef SHIFT_SKIP_ZERO_EN
        state_d = first_set_stage({2'b00, cnt_q[1:0]});
`else
        state_d = St2;
`endif
      end
      St2: begin
        stage_amt  = 4'd2;
        stage_take = cnt_q[1];
`ifdef SHIFT_SKIP_ZERO_EN
        state_d = first_set_stage({3'b000, cnt_q[0]});
`else
        state_d = St1;
`endif
      end
      St1: begin
        stage_amt  = 4'd1;
        stage_take = cnt_q[0];
        state_d    = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (stage_take) begin
      data_d = stage_res;
    end

    // Capture the final value on entry to StDone; data_d already includes the last stage,
    // and in skip mode with cnt = 0 it is the freshly latched operand.
    if (state_d == StDone && state_q != StDone) begin
      out_d = data_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign out  = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  cnt;
  logic [15:0] in;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int tests_run;
  int tests_failed;

  shift_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .cnt   (cnt),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] c);
`ifdef SHIFT_SKIP_ZERO_EN
    return 1 + int'(c[0]) + int'(c[1]) + int'(c[2]) + int'(c[3]);
`else
    return 5;
`endif
  endfunction

  // Issue one operation, optionally poke an extra start (in = FFFF) at cycle 2,
  // then check latency, result, single done pulse and out hold.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] c,
                        input logic [15:0] d, input logic [15:0] exp_out, input bit poke);
    int lat;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    cnt   = c;
    in    = d;
    @(negedge clk);
    // Operands must not be relatched after acceptance.
    start = 1'b0;
    op    = ~o;
    cnt   = ~c;
    in    = ~d;
    lat   = 1;
    while (done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 2) begin
        start = 1'b1;
        in    = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, " latency"}, lat, exp_latency(c));
    check_eq({tag, " out"}, {16'h0, out}, {16'h0, exp_out});
    check_eq({tag, " busy@done"}, {31'h0, busy}, 32'h1);
    @(negedge clk);
    check_eq({tag, " done pulse"}, {31'h0, done}, 32'h0);
    check_eq({tag, " idle"}, {31'h0, busy}, 32'h0);
    check_eq({tag, " out hold"}, {16'h0, out}, {16'h0, exp_out});
  endtask

  initial begin
    int seen_done;
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    cnt   = 4'd0;
    in    = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("reset busy", {31'h0, busy}, 32'h0);
    check_eq("reset done", {31'h0, done}, 32'h0);
    check_eq("reset out", {16'h0, out}, 32'h0);

    run_op("rol8",       2'b00, 4'd8,    16'h12F4, 16'hF412, 1'b0);
    run_op("sll3 poke",  2'b01, 4'd3,    16'h8001, 16'h0008, 1'b1);
    check_eq("ignored start no done", {31'h0, done}, 32'h0);
    run_op("sra4",       2'b10, 4'd4,    16'h8F00, 16'hF8F0, 1'b0);
    run_op("srl4",       2'b11, 4'd4,    16'h8F00, 16'h08F0, 1'b0);
    run_op("srl15",      2'b11, 4'd15,   16'h8000, 16'h0001, 1'b0);
    run_op("rol15",      2'b00, 4'd15,   16'h0001, 16'h8000, 1'b0);
    run_op("cnt0",       2'b01, 4'd0,    16'hBEEF, 16'hBEEF, 1'b0);
    run_op("sll5",       2'b01, 4'b0101, 16'h0001, 16'h0020, 1'b0);
    run_op("sra5",       2'b10, 4'd5,    16'h8400, 16'hFC20, 1'b0);

    // Reset mid-operation (cycle 2 after accept is stage 4 for cnt = 15).
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    cnt   = 4'd15;
    in    = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst mid busy", {31'h0, busy}, 32'h0);
    check_eq("rst mid done", {31'h0, done}, 32'h0);
    check_eq("rst mid out", {16'h0, out}, 32'h0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    check_eq("rst no late done", seen_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
